// File: rtl/display_button_scanner.sv
// display_button_scanner
//
// Serial-to-parallel front end for the display-board push buttons. It drives a
// 74HC165-style parallel-in/serial-out register and shifts its contents in
// MSB-first. Each complete scan is published as one stable parallel word for
// the displaybuttons PIO. The block scans continuously from reset.
//
// Ports
//   clk          in   system clock (CLOCK_50 domain)
//   reset_n      in   asynchronous active-low reset
//   shift_out    in   serial data from the register (asynchronous, synchronised here)
//   shift_load   out  active-low parallel load strobe to the register
//   shift_clkin  out  shift clock; the register advances on its rising edge
//   buttons      out  last complete scan, XORed with INVERT
//   scan_done    out  one-cycle pulse when buttons is updated
//   changed      out  one-cycle pulse with scan_done when buttons took a new value
//   dbg_state_o  out  current FSM state, for observation only
//
// Every output is registered. Its next value is derived from the next FSM
// state, so each output changes on the same edge as the state it belongs to.

module display_button_scanner #(
    parameter int NUM_BITS = 8,     // bits shifted per scan (2..32)
    parameter int CLK_DIV  = 4,     // clk cycles per shift-clock phase / load pulse (>= 2)
    parameter int SCAN_GAP = 0,     // idle clk cycles between scans (0..65535)
    parameter bit INVERT   = 1'b1   // 1: buttons = ~raw (active-low switches)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                shift_out,
    output logic                shift_load,
    output logic                shift_clkin,
    output logic [NUM_BITS-1:0] buttons,
    output logic                scan_done,
    output logic                changed,
    output logic [2:0]          dbg_state_o
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int IW = $clog2(NUM_BITS);

    localparam logic [PW-1:0]       PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(NUM_BITS - 1);
    localparam logic [15:0]         GAP_LEN  = 16'(SCAN_GAP);
    localparam logic [NUM_BITS-1:0] INV_MASK = {NUM_BITS{INVERT}};

    // GAP is encoded as zero. Reset therefore clears the state into GAP with
    // an empty gap counter, and GAP then exits to LOAD on the first edge
    // after reset is released.
    typedef enum logic [2:0] {
        ST_GAP  = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [15:0]         gap_q, gap_d;
    logic [NUM_BITS-1:0] cap_q, cap_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic [1:0]          sync_q;
    logic                scan_done_q, scan_done_d;
    logic                changed_q, changed_d;
    logic                shift_load_q, shift_load_d;
    logic                shift_clkin_q, shift_clkin_d;
    logic                phase_last;

    assign phase_last = (phase_q == PH_LAST);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + PW'(1);
        idx_d       = idx_q;
        gap_d       = gap_q;
        cap_d       = cap_q;
        buttons_d   = buttons_q;
        scan_done_d = 1'b0;
        changed_d   = 1'b0;

        case (state_q)
            ST_GAP: begin
                phase_d = '0;
                // The gap counter counts down from SCAN_GAP. A value of 0 or 1
                // means this is the last idle cycle.
                if (gap_q <= 16'd1) begin
                    state_d = ST_LOAD;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            ST_LOAD: begin
                if (phase_last) begin
                    state_d = ST_LOW;
                    phase_d = '0;
                    idx_d   = '0;
                end
            end
            ST_LOW: begin
                if (phase_last) begin
                    // Sample at the end of the low phase. Register data has been
                    // stable for 2*CLK_DIV-1 cycles here, which covers the
                    // synchroniser delay.
                    cap_d   = {cap_q[NUM_BITS-2:0], sync_q[1]};
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_DONE;
                        buttons_d   = cap_d ^ INV_MASK;
                        scan_done_d = 1'b1;
                        changed_d   = (buttons_d != buttons_q);
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (phase_last) begin
                    state_d = ST_LOW;
                    phase_d = '0;
                    idx_d   = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                phase_d = '0;
                if (SCAN_GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LEN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_GAP;
                phase_d = '0;
                gap_d   = '0;
            end
        endcase

        shift_load_d  = (state_d != ST_LOAD);
        shift_clkin_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_GAP;
            phase_q       <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            cap_q         <= '0;
            buttons_q     <= '0;
            sync_q        <= '0;
            scan_done_q   <= 1'b0;
            changed_q     <= 1'b0;
            shift_load_q  <= 1'b1;
            shift_clkin_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            cap_q         <= cap_d;
            buttons_q     <= buttons_d;
            sync_q        <= {sync_q[0], shift_out};
            scan_done_q   <= scan_done_d;
            changed_q     <= changed_d;
            shift_load_q  <= shift_load_d;
            shift_clkin_q <= shift_clkin_d;
        end
    end

    assign shift_load  = shift_load_q;
    assign shift_clkin = shift_clkin_q;
    assign buttons     = buttons_q;
    assign scan_done   = scan_done_q;
    assign changed     = changed_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_display_button_scanner.sv
// Bench for display_button_scanner. Instance A uses the default parameters.
// Instance B uses NUM_BITS=16, CLK_DIV=2, SCAN_GAP=10, INVERT=0.
// Each instance drives a behavioural 74HC165 model. DUT outputs are sampled on
// the falling clock edge.

module tb_display_button_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A (defaults) ----------------
    logic       rst_a = 1'b0;
    logic       so_a;
    logic       ld_a, ck_a, sd_a, chg_a;
    logic [7:0] btn_a;
    logic [2:0] st_a;
    logic [7:0] pat_a = 8'b1010_0110;
    logic [7:0] sr_a  = 8'h00;

    display_button_scanner dut_a (
        .clk(clk), .reset_n(rst_a), .shift_out(so_a),
        .shift_load(ld_a), .shift_clkin(ck_a), .buttons(btn_a),
        .scan_done(sd_a), .changed(chg_a), .dbg_state_o(st_a)
    );

    // 74HC165: parallel load while SH/LD is low, shift toward QH on CLK rise.
    always @(negedge ld_a or posedge ck_a) begin
        if (!ld_a) sr_a <= pat_a;
        else       sr_a <= {sr_a[6:0], 1'b0};
    end
    assign so_a = sr_a[7];

    // ---------------- instance B (16 bits, fast, gap, no invert) ----------------
    logic        rst_b = 1'b0;
    logic        so_b;
    logic        ld_b, ck_b, sd_b, chg_b;
    logic [15:0] btn_b;
    logic [2:0]  st_b;
    logic [15:0] pat_b = 16'hC3A5;
    logic [15:0] sr_b  = 16'h0000;

    display_button_scanner #(
        .NUM_BITS(16), .CLK_DIV(2), .SCAN_GAP(10), .INVERT(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .shift_out(so_b),
        .shift_load(ld_b), .shift_clkin(ck_b), .buttons(btn_b),
        .scan_done(sd_b), .changed(chg_b), .dbg_state_o(st_b)
    );

    always @(negedge ld_b or posedge ck_b) begin
        if (!ld_b) sr_b <= pat_b;
        else       sr_b <= {sr_b[14:0], 1'b0};
    end
    assign so_b = sr_b[15];

    // ---------------- protocol checkers ----------------
    int   ld_run_a = 0, hi_run_a = 0, rises_a = 0;
    logic prev_ck_a = 1'b0, prev_sd_a = 1'b0;

    always @(negedge clk) begin
        if (!rst_a) begin
            ld_run_a = 0; hi_run_a = 0; rises_a = 0;
            prev_ck_a = 1'b0; prev_sd_a = 1'b0;
        end else begin
            check("a_overlap", 32'(!ld_a && ck_a), 32'd0);
            if (!ld_a) ld_run_a++;
            else if (ld_run_a != 0) begin check("a_load_len", ld_run_a, 32'd4); ld_run_a = 0; end
            if (ck_a) hi_run_a++;
            else if (hi_run_a != 0) begin check("a_high_len", hi_run_a, 32'd4); hi_run_a = 0; end
            if (ck_a && !prev_ck_a) rises_a++;
            if (sd_a) begin
                check("a_rises", rises_a, 32'd7);
                check("a_done_twice", 32'(prev_sd_a), 32'd0);
                rises_a = 0;
            end
            prev_ck_a = ck_a;
            prev_sd_a = sd_a;
        end
    end

    int   ld_run_b = 0, hi_run_b = 0, rises_b = 0;
    logic prev_ck_b = 1'b0, prev_sd_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_b) begin
            ld_run_b = 0; hi_run_b = 0; rises_b = 0;
            prev_ck_b = 1'b0; prev_sd_b = 1'b0;
        end else begin
            check("b_overlap", 32'(!ld_b && ck_b), 32'd0);
            if (!ld_b) ld_run_b++;
            else if (ld_run_b != 0) begin check("b_load_len", ld_run_b, 32'd2); ld_run_b = 0; end
            if (ck_b) hi_run_b++;
            else if (hi_run_b != 0) begin check("b_high_len", hi_run_b, 32'd2); hi_run_b = 0; end
            if (ck_b && !prev_ck_b) rises_b++;
            if (sd_b) begin
                check("b_rises", rises_b, 32'd15);
                check("b_done_twice", 32'(prev_sd_b), 32'd0);
                rises_b = 0;
            end
            prev_ck_b = ck_b;
            prev_sd_b = sd_b;
        end
    end

    // Counts falling edges until scan_done is seen, giving up after limit.
    task automatic wait_done(input bit sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? sd_b : sd_a) && n < limit);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_load"},  32'(ld_a),  32'd1);
        check({tag, "_clkin"}, 32'(ck_a),  32'd0);
        check({tag, "_btn"},   32'(btn_a), 32'd0);
        check({tag, "_done"},  32'(sd_a),  32'd0);
        check({tag, "_chg"},   32'(chg_a), 32'd0);
    endtask

    int n;
    int rises;
    logic prev;

    initial begin
        // ---- reset held over several edges ----
        repeat (4) @(negedge clk);
        check_reset_a("a_rst");
        check("b_rst_load",  32'(ld_b),  32'd1);
        check("b_rst_clkin", 32'(ck_b),  32'd0);
        check("b_rst_btn",   32'(btn_b), 32'd0);

        // ---- basic scan: 1010_0110 -> buttons 0101_1001 after 65 cycles ----
        #2 rst_a = 1'b1;
        @(negedge clk);
        check("a_first_load", 32'(ld_a), 32'd0);
        wait_done(1'b0, 200, n);
        check("a_first_period", n + 1, 32'd65);   // +1 for the LOAD cycle above
        check("a_btn1", 32'(btn_a), 32'h59);
        check("a_chg1", 32'(chg_a), 32'd1);

        // ---- steady input: two more scans, no change ----
        wait_done(1'b0, 200, n);
        check("a_period2", n, 32'd65);
        check("a_btn2", 32'(btn_a), 32'h59);
        check("a_chg2", 32'(chg_a), 32'd0);
        @(negedge clk);
        check("a_hold_done", 32'(sd_a), 32'd0);
        check("a_hold_btn", 32'(btn_a), 32'h59);
        wait_done(1'b0, 200, n);
        check("a_period3", n, 32'd64);            // one cycle consumed by the hold check
        check("a_btn3", 32'(btn_a), 32'h59);
        check("a_chg3", 32'(chg_a), 32'd0);

        // ---- new pattern, loaded by the very next scan ----
        pat_a = 8'h0F;
        wait_done(1'b0, 200, n);
        check("a_period4", n, 32'd65);
        check("a_btn4", 32'(btn_a), 32'hF0);
        check("a_chg4", 32'(chg_a), 32'd1);

        // ---- mid-scan reset after 3 shift_clkin rises ----
        pat_a = 8'h3C;
        rises = 0;
        prev  = ck_a;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (ck_a && !prev) rises++;
            prev = ck_a;
        end while (rises < 3 && n < 200);
        check("a_rise_wait", rises, 32'd3);
        #2 rst_a = 1'b0;
        #1 check_reset_a("a_midrst");
        repeat (3) @(negedge clk);
        check("a_midrst_btn_hold", 32'(btn_a), 32'd0);
        #2 rst_a = 1'b1;
        @(negedge clk);
        check("a_restart_load", 32'(ld_a), 32'd0);
        check("a_restart_btn", 32'(btn_a), 32'd0);
        wait_done(1'b0, 200, n);
        check("a_restart_period", n + 1, 32'd65);
        check("a_btn5", 32'(btn_a), 32'hC3);
        check("a_chg5", 32'(chg_a), 32'd1);

        // ---- instance B: 16 bits, CLK_DIV=2, SCAN_GAP=10, INVERT=0 ----
        #2 rst_b = 1'b1;
        @(negedge clk);
        check("b_first_load", 32'(ld_b), 32'd0);
        wait_done(1'b1, 200, n);
        check("b_first_period", n + 1, 32'd65);  // no gap before the first scan
        check("b_btn1", 32'(btn_b), 32'hC3A5);
        check("b_chg1", 32'(chg_b), 32'd1);
        wait_done(1'b1, 200, n);
        check("b_period2", n, 32'd75);
        check("b_btn2", 32'(btn_b), 32'hC3A5);
        check("b_chg2", 32'(chg_b), 32'd0);
        @(negedge clk);
        check("b_gap_load", 32'(ld_b), 32'd1);
        check("b_gap_clkin", 32'(ck_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
